// File: rtl/sha_256_compress.sv
// SHA-256 compression engine: 64 rounds over an externally held schedule W[0..63], then chaining add.
// Latency: start sampled at edge N -> rounds N+1..N+64, chaining add at N+65, o_done visible for one cycle after N+65.
// Backpressure: none; i_start while o_busy is ignored (no queueing), i_w must stay stable until the last round.
module sha_256_compress #(
    parameter logic [255:0] H_INIT =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [31:0]   i_w [0:63],
    input  logic          i_start,
    input  logic          i_first,
    output logic          o_busy,
    output logic          o_done,
    output logic [255:0]  o_hash
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Big-sigma functions: fixed rotations expressed as bit concatenations.
    function automatic logic [31:0] f_bsig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] f_bsig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic [5:0]    r_cnt;
    logic [31:0]   r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
    logic [255:0]  r_hash;
    logic          r_busy;
    logic          r_done;

    logic [31:0]   w_k;
    logic [31:0]   w_wt;
    logic [31:0]   w_ch;
    logic [31:0]   w_maj;
    logic [31:0]   w_t1;
    logic [31:0]   w_t2;

    assign w_k   = K[r_cnt];
    assign w_wt  = i_w[r_cnt];
    assign w_ch  = (r_e & r_f) ^ (~r_e & r_g);
    assign w_maj = (r_a & r_b) ^ (r_a & r_c) ^ (r_b & r_c);
    assign w_t1  = r_h + f_bsig1(r_e) + w_ch + w_k + w_wt;
    assign w_t2  = f_bsig0(r_a) + w_maj;

    // State register; reset discards any block in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: start only accepted from IDLE, exit ROUND after round 63.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = ROUND;
            ROUND:   if (r_cnt == 6'd63) w_state_nxt = FINAL;
            FINAL:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: working-variable load, one round per cycle, chaining add, registered status flags.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt  <= 6'd0;
            r_a    <= 32'd0;
            r_b    <= 32'd0;
            r_c    <= 32'd0;
            r_d    <= 32'd0;
            r_e    <= 32'd0;
            r_f    <= 32'd0;
            r_g    <= 32'd0;
            r_h    <= 32'd0;
            r_hash <= H_INIT;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != IDLE);
            r_done <= (r_state == FINAL);
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_cnt <= 6'd0;
                        if (i_first) begin
                            {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= H_INIT;
                            r_hash <= H_INIT;
                        end else begin
                            {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= r_hash;
                        end
                    end
                end
                ROUND: begin
                    r_h   <= r_g;
                    r_g   <= r_f;
                    r_f   <= r_e;
                    r_e   <= r_d + w_t1;
                    r_d   <= r_c;
                    r_c   <= r_b;
                    r_b   <= r_a;
                    r_a   <= w_t1 + w_t2;
                    r_cnt <= r_cnt + 6'd1;
                end
                FINAL: begin
                    r_hash[255:224] <= r_hash[255:224] + r_a;
                    r_hash[223:192] <= r_hash[223:192] + r_b;
                    r_hash[191:160] <= r_hash[191:160] + r_c;
                    r_hash[159:128] <= r_hash[159:128] + r_d;
                    r_hash[127:96]  <= r_hash[127:96]  + r_e;
                    r_hash[95:64]   <= r_hash[95:64]   + r_f;
                    r_hash[63:32]   <= r_hash[63:32]   + r_g;
                    r_hash[31:0]    <= r_hash[31:0]    + r_h;
                end
                default: ;
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_hash = r_hash;

endmodule

// File: tb/tb_sha_256_compress.sv
// Bench for sha_256_compress: known digests, chaining, ignored starts, mid-block reset, random blocks.
// Expected digests come from literal vectors or a word-array SHA-256 model; a monitor pops a scoreboard on o_done.
// Timing of o_done is checked against the start cycle + 66.
module tb_sha_256_compress;

    localparam logic [255:0] H_INIT = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] D_ABC  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_TWO  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [31:0] KT [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic          clk;
    logic          i_rst_n;
    logic          i_start;
    logic          i_first;
    logic [31:0]   w_bus [0:63];
    logic          o_busy;
    logic          o_done;
    logic [255:0]  o_hash;

    int            cyc;
    int            checks;
    int            errors;
    logic [31:0]   m [0:15];
    logic [255:0]  model_h;

    typedef struct {
        logic [255:0] hash;
        int           at_cyc;
    } exp_t;
    exp_t sbq [$];

    sha_256_compress dut (
        .i_clk   (clk),
        .i_rst_n (i_rst_n),
        .i_w     (w_bus),
        .i_start (i_start),
        .i_first (i_first),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_hash  (o_hash)
    );

    // Clock; cyc counts rising edges and only changes at them.
    initial begin
        clk = 1'b0;
        cyc = 0;
        forever begin
            #5 clk = 1'b1;
            cyc++;
            #5 clk = 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Message expansion of the 16 block words in m[] onto the DUT schedule bus.
    task automatic expand();
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                w_bus[t] = m[t];
            end else begin
                w_bus[t] = (rotr(w_bus[t-2], 17) ^ rotr(w_bus[t-2], 19) ^ (w_bus[t-2] >> 10))
                         + w_bus[t-7]
                         + (rotr(w_bus[t-15], 7) ^ rotr(w_bus[t-15], 18) ^ (w_bus[t-15] >> 3))
                         + w_bus[t-16];
            end
        end
    endtask

    function automatic logic [255:0] compress(input logic [255:0] hin);
        logic [31:0] v [8];
        logic [31:0] hv [8];
        logic [31:0] t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            hv[i] = hin[255 - 32*i -: 32];
            v[i]  = hv[i];
        end
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w_bus[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        r = '0;
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hv[i] + v[i];
        return r;
    endfunction

    // ---------------- block patterns ----------------
    task automatic set_abc();
        for (int i = 0; i < 16; i++) m[i] = 32'h0;
        m[0]  = 32'h61626380;
        m[15] = 32'h00000018;
        expand();
    endtask

    task automatic set_empty();
        for (int i = 0; i < 16; i++) m[i] = 32'h0;
        m[0] = 32'h80000000;
        expand();
    endtask

    task automatic set_two1();
        m[0]  = 32'h61626364; m[1]  = 32'h62636465; m[2]  = 32'h63646566; m[3]  = 32'h64656667;
        m[4]  = 32'h65666768; m[5]  = 32'h66676869; m[6]  = 32'h6768696a; m[7]  = 32'h68696a6b;
        m[8]  = 32'h696a6b6c; m[9]  = 32'h6a6b6c6d; m[10] = 32'h6b6c6d6e; m[11] = 32'h6c6d6e6f;
        m[12] = 32'h6d6e6f70; m[13] = 32'h6e6f7071; m[14] = 32'h80000000; m[15] = 32'h00000000;
        expand();
    endtask

    task automatic set_two2();
        for (int i = 0; i < 16; i++) m[i] = 32'h0;
        m[15] = 32'h000001c0;
        expand();
    endtask

    task automatic set_rand();
        for (int i = 0; i < 16; i++) m[i] = $urandom;
        expand();
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every o_done and checks digest and arrival cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (o_done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done cyc=%0d hash=%h", cyc, o_hash);
            end else begin
                e = sbq.pop_front();
                checks++;
                if (o_hash !== e.hash) begin
                    errors++;
                    $display("FAIL digest cyc=%0d got=%h exp=%h", cyc, o_hash, e.hash);
                end
                checks++;
                if (cyc != e.at_cyc) begin
                    errors++;
                    $display("FAIL done_cycle got=%0d exp=%0d", cyc, e.at_cyc);
                end
            end
        end else if (sbq.size() != 0 && cyc > sbq[0].at_cyc) begin
            checks++;
            errors++;
            $display("FAIL done_missing cyc=%0d exp_cyc=%0d", cyc, sbq[0].at_cyc);
            void'(sbq.pop_front());
        end
    end

    // Issue a start at the current negedge; prev is the o_hash expected right after acceptance.
    task automatic start_blk(input bit first, input bit expect_done,
                             input logic [255:0] exp_hash, input logic [255:0] prev);
        i_start = 1'b1;
        i_first = first;
        if (expect_done) sbq.push_back('{exp_hash, cyc + 66});
        @(negedge clk);
        i_start = 1'b0;
        i_first = 1'($urandom);
        chk("busy_after_start", {255'd0, o_busy}, 256'd1);
        chk("hash_after_start", o_hash, prev);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout cyc=%0d pending=%0d", cyc, sbq.size());
            sbq.delete();
        end
        @(negedge clk);
        chk("busy_idle", {255'd0, o_busy}, 256'd0);
    endtask

    task automatic run_model_blk(input bit first);
        logic [255:0] prev;
        prev    = first ? H_INIT : model_h;
        model_h = compress(prev);
        start_blk(first, 1'b1, model_h, prev);
        wait_drain();
    endtask

    task automatic run_known(input bit first, input logic [255:0] digest);
        logic [255:0] prev;
        prev    = first ? H_INIT : model_h;
        model_h = digest;
        start_blk(first, 1'b1, digest, prev);
        wait_drain();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks  = 0;
        errors  = 0;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_first = 1'b0;
        for (int i = 0; i < 64; i++) w_bus[i] = 32'h0;
        model_h = H_INIT;
        repeat (3) @(negedge clk);
        i_rst_n = 1'b1;
        chk("rst_busy", {255'd0, o_busy}, 256'd0);
        chk("rst_done", {255'd0, o_done}, 256'd0);
        chk("rst_hash", o_hash, H_INIT);
        @(negedge clk);

        // Known single-block vectors.
        set_abc();
        run_known(1'b1, D_ABC);
        set_empty();
        run_known(1'b1, D_EMPTY);

        // Two-block message, second start issued in the o_done cycle of the first.
        set_two1();
        model_h = compress(H_INIT);
        start_blk(1'b1, 1'b1, model_h, H_INIT);
        repeat (65) @(negedge clk);
        chk("b2b_done_cycle", {255'd0, o_done}, 256'd1);
        set_two2();
        start_blk(1'b0, 1'b1, D_TWO, model_h);
        model_h = D_TWO;
        wait_drain();

        // Starts during round 10, round 63 and the chaining-add cycle are ignored.
        set_abc();
        start_blk(1'b1, 1'b1, D_ABC, H_INIT);
        for (int k = 2; k <= 67; k++) begin
            @(negedge clk);
            i_start = (k == 11 || k == 64 || k == 65);
            i_first = 1'b0;
        end
        i_start = 1'b0;
        model_h = D_ABC;
        wait_drain();
        repeat (70) @(negedge clk);
        chk("ignore_hash_stable", o_hash, D_ABC);

        // Reset in round 30 discards the block; then a fresh run still matches.
        start_blk(1'b0, 1'b0, 256'd0, D_ABC);
        repeat (29) @(negedge clk);
        i_rst_n = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
        chk("midrst_busy", {255'd0, o_busy}, 256'd0);
        chk("midrst_hash", o_hash, H_INIT);
        chk("midrst_done", {255'd0, o_done}, 256'd0);
        model_h = H_INIT;
        repeat (80) @(negedge clk);
        chk("midrst_hash_held", o_hash, H_INIT);
        run_known(1'b1, D_ABC);

        // Chain a random block, then restart with i_first: no leak from the chain.
        set_rand();
        run_model_blk(1'b0);
        set_abc();
        run_known(1'b1, D_ABC);

        // Random blocks with random first flags against the model.
        for (int n = 0; n < 6; n++) begin
            set_rand();
            run_model_blk((n == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
